// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN accelerator layer scheduler: layer types,
// descriptor word0 field positions, sequencer state encodings and decoded fields.
package cnn_pkg;

    localparam int DESC_WORDS = 4;

    localparam logic [1:0] LT_CONV = 2'd0;
    localparam logic [1:0] LT_POOL = 2'd1;
    localparam logic [1:0] LT_FC   = 2'd2;
    localparam logic [1:0] LT_RSVD = 2'd3;

    localparam int W0_TYPE_LSB   = 30;
    localparam int W0_KNLS_LSB   = 25;
    localparam int W0_DEPTH_LSB  = 20;
    localparam int W0_WIDTH_LSB  = 14;
    localparam int W0_HEIGHT_LSB = 8;
    localparam int W0_LAST_BIT   = 0;

    localparam logic [4:0] MAX_CH       = 5'd16;
    localparam logic [5:0] MIN_CONV_DIM = 6'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_CHECK  = 3'd2,
        ST_LAUNCH = 3'd3,
        ST_WAIT   = 3'd4,
        ST_NEXT   = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    typedef struct packed {
        logic [1:0] ltype;
        logic [4:0] num_knls;
        logic [4:0] depth;
        logic [5:0] width;
        logic [5:0] height;
        logic       last;
        logic       valid;
    } desc_t;

    // Kernel and channel counts are legal only in 1..16.
    function automatic logic ch_in_range(input logic [4:0] v);
        return (v != 5'd0) && (v <= MAX_CH);
    endfunction

endpackage

// File: rtl/layer_desc_decode.sv
// Combinational decode and legality check of a layer descriptor's first word.
module layer_desc_decode
    import cnn_pkg::*;
(
    input  logic [31:0] word0,
    output desc_t       desc
);

    logic unused_s;
    logic conv_too_small_s;

    assign unused_s = ^word0[7:1];

    // Field extraction plus the reject rules applied before an engine launch.
    always_comb begin
        desc          = '0;
        desc.ltype    = word0[W0_TYPE_LSB +: 2];
        desc.num_knls = word0[W0_KNLS_LSB +: 5];
        desc.depth    = word0[W0_DEPTH_LSB +: 5];
        desc.width    = word0[W0_WIDTH_LSB +: 6];
        desc.height   = word0[W0_HEIGHT_LSB +: 6];
        desc.last     = word0[W0_LAST_BIT];
        conv_too_small_s = (desc.ltype == LT_CONV) &&
                           ((desc.width < MIN_CONV_DIM) || (desc.height < MIN_CONV_DIM));
        desc.valid    = (desc.ltype != LT_RSVD) && ch_in_range(desc.num_knls) &&
                        ch_in_range(desc.depth) && !conv_too_small_s;
    end

endmodule

// File: rtl/layer_sequencer.sv
// Walks the DRAM layer-descriptor table, publishes each layer's configuration
// to the engines, launches the selected engine and waits for its completion.
module layer_sequencer
    import cnn_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 18,
    parameter  int MAX_LAYERS = 8,
    parameter  int DESC_WORDS = cnn_pkg::DESC_WORDS,
    localparam int LIDX_W     = $clog2(MAX_LAYERS)
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] desc_base,
    input  logic                  dram_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_en_rd,
    output logic                  fetch_active,
    output logic [1:0]            eng_sel,
    output logic                  eng_enable,
    input  logic                  eng_done,
    output logic [4:0]            cfg_num_knls,
    output logic [4:0]            cfg_depth,
    output logic [5:0]            cfg_ifmap_width,
    output logic [5:0]            cfg_ifmap_height,
    output logic [ADDR_WIDTH-1:0] cfg_wts_base,
    output logic [ADDR_WIDTH-1:0] cfg_ifmap_base,
    output logic [ADDR_WIDTH-1:0] cfg_ofmap_base,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [LIDX_W-1:0]     layer_idx
);

    state_t                state_r, state_s;
    logic [2:0]            cnt_r;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [DATA_WIDTH-1:0] word0_r;
    logic [ADDR_WIDTH-1:0] word1_r, word2_r, word3_r;
    desc_t                 desc_s;

    layer_desc_decode u_decode (
        .word0 (word0_r[31:0]),
        .desc  (desc_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:   state_s = (start && dram_valid) ? ST_FETCH : ST_IDLE;
            ST_FETCH:  state_s = (cnt_r == 3'd4) ? ST_CHECK : ST_FETCH;
            ST_CHECK:  state_s = desc_s.valid ? ST_LAUNCH : ST_ERR;
            ST_LAUNCH: state_s = ST_WAIT;
            ST_WAIT:   state_s = eng_done ? ST_NEXT : ST_WAIT;
            ST_NEXT:   state_s = (desc_s.last || (layer_idx == LIDX_W'(MAX_LAYERS - 1)))
                                 ? ST_DONE : ST_FETCH;
            ST_DONE:   state_s = ST_IDLE;
            ST_ERR:    state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        fetch_active = 1'b0;
        fetch_en_rd  = 1'b0;
        fetch_addr   = '0;
        eng_enable   = 1'b0;
        done         = 1'b0;
        busy         = (state_r != ST_IDLE);
        case (state_r)
            ST_FETCH: begin
                fetch_active = 1'b1;
                if (cnt_r != 3'd4) begin
                    fetch_en_rd = 1'b1;
                    fetch_addr  = base_r + ADDR_WIDTH'(layer_idx) * ADDR_WIDTH'(DESC_WORDS)
                                  + ADDR_WIDTH'(cnt_r);
                end else begin
                    fetch_en_rd = 1'b0;
                    fetch_addr  = '0;
                end
            end
            ST_LAUNCH: eng_enable = 1'b1;
            ST_DONE:   done       = 1'b1;
            default:   eng_enable = 1'b0;
        endcase
    end

    // Fetch beat counter: read requests on 0..3, last data beat lands on 4.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            cnt_r <= 3'd0;
        end else if ((state_r == ST_FETCH) && (cnt_r != 3'd4)) begin
            cnt_r <= cnt_r + 3'd1;
        end else begin
            cnt_r <= 3'd0;
        end
    end

    // Capture returning words; data trails its request by one cycle.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            word0_r <= '0;
            word1_r <= '0;
            word2_r <= '0;
            word3_r <= '0;
        end else if (state_r == ST_FETCH) begin
            case (cnt_r)
                3'd1:    word0_r <= data_in;
                3'd2:    word1_r <= data_in[ADDR_WIDTH-1:0];
                3'd3:    word2_r <= data_in[ADDR_WIDTH-1:0];
                3'd4:    word3_r <= data_in[ADDR_WIDTH-1:0];
                default: word0_r <= word0_r;
            endcase
        end else begin
            word0_r <= word0_r;
        end
    end

    // Run bookkeeping: table base, layer index and the sticky error flag.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            base_r    <= '0;
            layer_idx <= '0;
            err       <= 1'b0;
        end else if ((state_r == ST_IDLE) && (state_s == ST_FETCH)) begin
            base_r    <= desc_base;
            layer_idx <= '0;
            err       <= 1'b0;
        end else if ((state_r == ST_NEXT) && (state_s == ST_FETCH)) begin
            layer_idx <= layer_idx + LIDX_W'(1);
        end else if ((state_r == ST_CHECK) && (state_s == ST_ERR)) begin
            err <= 1'b1;
        end else begin
            err <= err;
        end
    end

    // Engine configuration changes only when a legal descriptor is accepted.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            eng_sel          <= 2'd0;
            cfg_num_knls     <= 5'd0;
            cfg_depth        <= 5'd0;
            cfg_ifmap_width  <= 6'd0;
            cfg_ifmap_height <= 6'd0;
            cfg_wts_base     <= '0;
            cfg_ifmap_base   <= '0;
            cfg_ofmap_base   <= '0;
        end else if ((state_r == ST_CHECK) && desc_s.valid) begin
            eng_sel          <= desc_s.ltype;
            cfg_num_knls     <= desc_s.num_knls;
            cfg_depth        <= desc_s.depth;
            cfg_ifmap_width  <= desc_s.width;
            cfg_ifmap_height <= desc_s.height;
            cfg_wts_base     <= word1_r;
            cfg_ifmap_base   <= word2_r;
            cfg_ofmap_base   <= word3_r;
        end else begin
            eng_sel <= eng_sel;
        end
    end

endmodule
